// File: rtl/peri_pkg.sv
// Shared definitions for the eFlash PIM peripheral: command modes, output-buffer
// FSM encoding, read-window offsets and status-word bit positions.
package peri_pkg;

  localparam logic [2:0] MODE_PIM = 3'b011;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } out_state_e;

  localparam logic [31:0] OB_DATA_OFS = 32'h0;
  localparam logic [31:0] OB_STAT_OFS = 32'h4;
  localparam logic [31:0] OB_LEFT_OFS = 32'h8;

  localparam int ST_EMPTY_BIT = 16;
  localparam int ST_FULL_BIT  = 17;
  localparam int ST_OVF_BIT   = 18;
  localparam int ST_DONE_BIT  = 19;
  localparam int ST_STATE_LSB = 20;

endpackage

// File: rtl/peri_sync_fifo.sv
// Synchronous 32-bit FIFO with registered read data and same-cycle push/pop,
// including push+pop while full (slot reuse) and while empty (pop yields 0).
module peri_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [31:0]      wdata_i,
  input  logic             pop_i,
  output logic [31:0]      rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_MAX);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = rdata_q;

  // A full FIFO still accepts a push when a pop frees the head slot this cycle.
  assign do_push = push_i && !clr_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !clr_i && !empty_o;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rdata_d  = rdata_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    if (pop_i) rdata_d = empty_o ? 32'h0 : mem_q[rd_ptr_q];
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rdata_d  = '0;
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: rtl/peri_out_buf_ctrl.sv
// PIM output-buffer controller: arms on a PIM command, captures exec_cnt+1 ADC
// words into a FIFO and serves host pop/status/words-left reads with latency 1.
module peri_out_buf_ctrl
  import peri_pkg::*;
#(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] RD_BASE = 32'h4000_0100,
  parameter int          CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pim_en_i,
  input  logic [2:0]  pim_mode_i,
  input  logic [3:0]  exec_cnt_i,
  input  logic        adc_valid_i,
  input  logic [31:0] adc_data_i,
  input  logic        rd_req_i,
  input  logic [31:0] rd_addr_i,
  input  logic        clr_i,
  output logic        rd_valid_o,
  output logic [31:0] rd_data_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o
);

  out_state_e       state_q, state_d;
  logic [4:0]       words_left_q, words_left_d;
  logic             done_q, done_d, ovf_q, ovf_d;
  logic             rd_valid_q, rd_valid_d, rd_pop_q, rd_pop_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic [31:0]      status_word;
  logic             push, pop;
  logic [31:0]      fifo_rdata;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign push = adc_valid_i && !clr_i && (state_q == ARMED || state_q == CAPTURE);
  assign pop  = rd_req_i && !clr_i && (rd_addr_i == RD_BASE + OB_DATA_OFS);

  peri_sync_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr_i   (clr_i),
    .push_i  (push),
    .wdata_i (adc_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    status_word                                = '0;
    status_word[CNT_W-1:0]                     = fifo_count;
    status_word[ST_EMPTY_BIT]                  = fifo_empty;
    status_word[ST_FULL_BIT]                   = fifo_full;
    status_word[ST_OVF_BIT]                    = ovf_q;
    status_word[ST_DONE_BIT]                   = done_q;
    status_word[ST_STATE_LSB+1:ST_STATE_LSB]   = state_q;
  end

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    rd_valid_d   = rd_req_i;
    rd_pop_d     = 1'b0;
    rd_data_d    = 32'h0;

    if (rd_req_i) begin
      case (rd_addr_i)
        RD_BASE + OB_DATA_OFS: rd_pop_d  = 1'b1;
        RD_BASE + OB_STAT_OFS: rd_data_d = status_word;
        RD_BASE + OB_LEFT_OFS: rd_data_d = {27'h0, words_left_q};
        default:               rd_data_d = 32'h0;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (pim_en_i && pim_mode_i == MODE_PIM) begin
          state_d      = ARMED;
          words_left_d = {1'b0, exec_cnt_i} + 5'd1;
          done_d       = 1'b0;
        end
      end
      ARMED, CAPTURE: begin
        if (adc_valid_i) begin
          words_left_d = words_left_q - 5'd1;
          if (words_left_q == 5'd1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A dropped word still counts toward the command; only the flag records the loss.
    if (push && fifo_full && !pop) ovf_d = 1'b1;

    if (clr_i) begin
      state_d      = IDLE;
      words_left_d = '0;
      done_d       = 1'b0;
      ovf_d        = 1'b0;
      rd_valid_d   = 1'b0;
      rd_pop_d     = 1'b0;
      rd_data_d    = 32'h0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_pop_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
      rd_valid_q   <= rd_valid_d;
      rd_pop_q     <= rd_pop_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Pop responses come straight from the FIFO's registered read port.
  assign rd_data_o  = rd_pop_q ? fifo_rdata : rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = (state_q == ARMED) || (state_q == CAPTURE);
  assign done_o     = done_q;
  assign ovf_o      = ovf_q;

endmodule
